// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: streams LED_NUM pixels from a synchronous RAM to the word
// serializer, one word ahead in a prefetch buffer, then holds the line in latch/reset.
module ws2812_frame_ctrl #(
  parameter int LED_NUM      = 64,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 60000
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       rgb_out,
  output logic              en_out,
  input  logic              word_done,
  output logic              latch_active
);

  localparam int LC_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(LED_NUM - 1);
  localparam logic [LC_W-1:0]   LAST_LATCH = LC_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, SEND, LATCH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_nxt;
  logic [LC_W-1:0]   latch_cnt, latch_cnt_nxt;
  logic [23:0]       next_buf, next_buf_nxt;
  logic              fetch_req, fetch_req_nxt;
  logic              cap_pend, cap_pend_nxt;
  logic              busy_nxt, done_nxt, rd_en_nxt, en_out_nxt, latch_active_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [23:0]       rgb_out_nxt;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      latch_cnt    <= '0;
      next_buf     <= '0;
      fetch_req    <= 1'b0;
      cap_pend     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      rgb_out      <= '0;
      en_out       <= 1'b0;
      latch_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      pix_cnt      <= pix_cnt_nxt;
      latch_cnt    <= latch_cnt_nxt;
      next_buf     <= next_buf_nxt;
      fetch_req    <= fetch_req_nxt;
      cap_pend     <= cap_pend_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      rd_en        <= rd_en_nxt;
      rd_addr      <= rd_addr_nxt;
      rgb_out      <= rgb_out_nxt;
      en_out       <= en_out_nxt;
      latch_active <= latch_active_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pix_cnt_nxt      = pix_cnt;
    latch_cnt_nxt    = latch_cnt;
    next_buf_nxt     = next_buf;
    fetch_req_nxt    = fetch_req;
    cap_pend_nxt     = cap_pend;
    busy_nxt         = busy;
    done_nxt         = 1'b0;
    rd_en_nxt        = 1'b0;
    rd_addr_nxt      = rd_addr;
    rgb_out_nxt      = rgb_out;
    en_out_nxt       = en_out;
    latch_active_nxt = latch_active;

    case (state)
      IDLE: begin
        if (start) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = '0;
          busy_nxt    = 1'b1;
          state_nxt   = PREFETCH;
        end
      end
      PREFETCH: state_nxt = LOAD;
      LOAD: begin
        rgb_out_nxt   = rd_data;
        en_out_nxt    = 1'b1;
        pix_cnt_nxt   = '0;
        fetch_req_nxt = (LED_NUM > 1);
        cap_pend_nxt  = 1'b0;
        state_nxt     = SEND;
      end
      SEND: begin
        // Read issued last cycle is sampled by the RAM now; its data lands next cycle.
        if (cap_pend) begin
          next_buf_nxt = rd_data;
          cap_pend_nxt = 1'b0;
        end
        if (rd_en) cap_pend_nxt = 1'b1;
        if (fetch_req) begin
          rd_en_nxt     = 1'b1;
          rd_addr_nxt   = pix_cnt + 1'b1;
          fetch_req_nxt = 1'b0;
        end
        if (word_done) begin
          if (pix_cnt == LAST_PIX) begin
            en_out_nxt       = 1'b0;
            latch_active_nxt = 1'b1;
            latch_cnt_nxt    = '0;
            fetch_req_nxt    = 1'b0;
            state_nxt        = LATCH;
          end else begin
            rgb_out_nxt   = next_buf;
            pix_cnt_nxt   = pix_cnt + 1'b1;
            fetch_req_nxt = ((pix_cnt + 1'b1) != LAST_PIX);
          end
        end
      end
      LATCH: begin
        if (latch_cnt == LAST_LATCH) begin
          latch_active_nxt = 1'b0;
          busy_nxt         = 1'b0;
          done_nxt         = 1'b1;
          state_nxt        = IDLE;
        end else begin
          latch_cnt_nxt = latch_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
